ahb2apb_bridge: RTL and testbench



---
 rtl/ahb_apb_defs.sv | 36 +++
 rtl/apb_slv_decoder.sv | 21 ++
 rtl/ahb2apb_bridge.sv | 127 ++++++++++++
 tb/tb_ahb2apb_bridge.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_defs.sv
// Shared widths, AHB encodings and bridge state encoding for the AHB-to-APB bridge.
package ahb_apb_defs;

    localparam int unsigned HADDR_WIDTH    = 32;
    localparam int unsigned PADDR_WIDTH    = 16;
    localparam int unsigned AHB_DATA_WIDTH = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned HTRANS_WIDTH   = 2;
    localparam int unsigned HSIZE_WIDTH    = 3;
    localparam int unsigned HBURST_WIDTH   = 3;

    typedef enum logic [HTRANS_WIDTH-1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    // Largest supported transfer: word
    localparam logic [HSIZE_WIDTH-1:0] HSIZE_MAX = 3'd2;

endpackage

// File: rtl/apb_slv_decoder.sv
// Maps the latched 4-bit slave index to a one-hot APB select plus a hit flag.
module apb_slv_decoder #(
    parameter int unsigned NUM_SLV = 12
) (
    input  logic [3:0]         slv_idx,
    output logic [NUM_SLV-1:0] sel,
    output logic               hit
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (slv_idx == 4'(i)) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB slave front end that runs one APB SETUP/ACCESS sequence per accepted transfer.
module ahb2apb_bridge
    import ahb_apb_defs::*;
#(
    parameter int unsigned NUM_SLV = 12,
    parameter int unsigned SEL_LSB = 12,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [HADDR_WIDTH-1:0]    haddr,
    input  logic                      hsel,
    input  logic                      hready,
    input  logic [HTRANS_WIDTH-1:0]   htrans,
    input  logic                      hwrite,
    input  logic [HSIZE_WIDTH-1:0]    hsize,
    input  logic [HBURST_WIDTH-1:0]   hburst,
    input  logic [AHB_DATA_WIDTH-1:0] hwdata,
    output logic [AHB_DATA_WIDTH-1:0] hrdata,
    output logic                      hreadyout,
    output logic                      hresp,
    output logic [NUM_SLV-1:0]        psel_vec,
    output logic                      penable,
    output logic [PADDR_WIDTH-1:0]    paddr,
    output logic                      pwrite,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TMO_LIM = (CNT_W + 1)'(TIMEOUT);

    bridge_state_e state, state_next;

    logic [3:0]             idx_q;
    logic [PADDR_WIDTH-1:0] addr_q;
    logic                   write_q;
    logic [HSIZE_WIDTH-1:0] size_q;
    logic [CNT_W-1:0]       tmo_cnt;
    logic [NUM_SLV-1:0]     dec_sel;
    logic                   dec_hit;
    logic                   accept;
    logic                   tmo_hit;
    logic                   unused_ok;

    assign accept    = hsel & hready & htrans[1] & hreadyout;
    // Fires on the ACCESS cycle that would bring the wait count up to TIMEOUT
    assign tmo_hit   = (TIMEOUT != 0) && !pready &&
                       (({1'b0, tmo_cnt} + (CNT_W + 1)'(1)) == TMO_LIM);
    assign unused_ok = ^{hburst, haddr, htrans[0]};

    apb_slv_decoder #(
        .NUM_SLV (NUM_SLV)
    ) u_dec (
        .slv_idx (idx_q),
        .sel     (dec_sel),
        .hit     (dec_hit)
    );

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) state <= ST_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_LATCH;
            ST_LATCH:  state_next = (dec_hit && size_q <= HSIZE_MAX) ? ST_SETUP : ST_ERR1;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (pready)       state_next = pslverr ? ST_ERR1 : ST_IDLE;
                else if (tmo_hit) state_next = ST_ERR1;
            end
            ST_ERR1:   state_next = ST_ERR2;
            ST_ERR2:   state_next = accept ? ST_LATCH : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // All bus outputs are registered from the next state so they change on clock edges only
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            idx_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
            tmo_cnt   <= '0;
            hrdata    <= '0;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            psel_vec  <= '0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            if (accept) begin
                idx_q   <= haddr[SEL_LSB +: 4];
                addr_q  <= haddr[PADDR_WIDTH-1:0];
                write_q <= hwrite;
                size_q  <= hsize;
            end
            if (state == ST_LATCH && write_q) pwdata <= hwdata;

            if (state_next == ST_SETUP) begin
                psel_vec <= dec_sel;
                paddr    <= addr_q;
                pwrite   <= write_q;
            end else if (state_next != ST_ACCESS) begin
                psel_vec <= '0;
            end

            penable   <= (state_next == ST_ACCESS);
            hreadyout <= (state_next == ST_IDLE) || (state_next == ST_ERR2);
            hresp     <= (state_next == ST_ERR1) || (state_next == ST_ERR2);

            if (state == ST_ACCESS && pready && !pslverr && !write_q) hrdata <= prdata;

            if (state != ST_ACCESS)                 tmo_cnt <= '0;
            else if (!pready && tmo_cnt != '1)      tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Scoreboard bench: driver pushes expected AHB/APB outcomes, monitors pop and compare.
module tb_ahb2apb_bridge;
    import ahb_apb_defs::*;

    localparam int unsigned NSLV = 12;
    localparam int unsigned SLSB = 12;
    localparam int unsigned TMO  = 8;

    logic                      hclk = 1'b0;
    logic                      hreset_n;
    logic [HADDR_WIDTH-1:0]    haddr;
    logic                      hsel;
    logic                      hready;
    logic [HTRANS_WIDTH-1:0]   htrans;
    logic                      hwrite;
    logic [HSIZE_WIDTH-1:0]    hsize;
    logic [HBURST_WIDTH-1:0]   hburst;
    logic [AHB_DATA_WIDTH-1:0] hwdata;
    logic [AHB_DATA_WIDTH-1:0] hrdata;
    logic                      hreadyout;
    logic                      hresp;
    logic [NSLV-1:0]           psel_vec;
    logic                      penable;
    logic [PADDR_WIDTH-1:0]    paddr;
    logic                      pwrite;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    always #5 hclk = ~hclk;

    ahb2apb_bridge #(
        .NUM_SLV (NSLV),
        .SEL_LSB (SLSB),
        .TIMEOUT (TMO)
    ) dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .haddr     (haddr),
        .hsel      (hsel),
        .hready    (hready),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .psel_vec  (psel_vec),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    typedef struct {
        logic [NSLV-1:0]        sel;
        logic [PADDR_WIDTH-1:0] paddr;
        logic                   wr;
        logic [31:0]            wdata;
        int unsigned            waits;
        logic                   err;
        logic [31:0]            rdata;
        int unsigned            cycles;
    } apb_rec_t;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int unsigned lat;
    } ahb_rec_t;

    apb_rec_t    apb_q[$];
    ahb_rec_t    ahb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] model_rdata = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Leaves the caller at a negedge where hreadyout is high
    task automatic wait_ready();
        int unsigned n = 0;
        @(negedge hclk);
        hwdata = $urandom;
        while (!hreadyout && n < 200) begin
            @(negedge hclk);
            hwdata = $urandom;
            n++;
        end
        if (!hreadyout) check("ready_wait", {63'd0, hreadyout}, 64'd1);
    endtask

    task automatic issue(input logic [31:0] addr, input bit wr, input int unsigned size,
                         input logic [31:0] wdata, input int unsigned waits,
                         input bit err, input logic [31:0] rdata);
        ahb_rec_t    a;
        apb_rec_t    p;
        int unsigned idx;
        logic [31:0] r;
        wait_ready();
        idx = (addr / 4096) % 16;
        if (idx >= NSLV || size > 2) begin
            a.resp = 1'b1;
            a.lat  = 3;
        end else begin
            p.sel    = NSLV'(1) << idx;
            p.paddr  = addr[PADDR_WIDTH-1:0];
            p.wr     = wr;
            p.wdata  = wdata;
            p.waits  = waits;
            p.err    = err;
            p.rdata  = rdata;
            p.cycles = (waits >= TMO) ? TMO : waits + 1;
            apb_q.push_back(p);
            if (waits >= TMO) begin
                a.resp = 1'b1;
                a.lat  = TMO + 4;
            end else if (err) begin
                a.resp = 1'b1;
                a.lat  = waits + 5;
            end else begin
                a.resp = 1'b0;
                a.lat  = waits + 4;
                if (!wr) model_rdata = rdata;
            end
        end
        a.rdata = model_rdata;
        ahb_q.push_back(a);
        r      = $urandom;
        hsel   = 1'b1;
        haddr  = addr;
        htrans = r[0] ? HTRANS_SEQ : HTRANS_NONSEQ;
        hwrite = wr;
        hsize  = HSIZE_WIDTH'(size);
        hburst = r[3:1];
        @(negedge hclk);
        hwdata = wdata;
        hsel   = r[4];
        htrans = r[5] ? HTRANS_BUSY : HTRANS_IDLE;
        haddr  = $urandom;
    endtask

    task automatic idle_xfer();
        logic [31:0] r;
        wait_ready();
        r      = $urandom;
        hsel   = 1'b1;
        htrans = r[0] ? HTRANS_BUSY : HTRANS_IDLE;
        haddr  = $urandom;
        hwrite = r[1];
        @(negedge hclk);
        check("idle_hreadyout", {63'd0, hreadyout}, 64'd1);
        check("idle_hresp", {63'd0, hresp}, 64'd0);
        check("idle_psel", 64'(psel_vec), 64'd0);
        hsel = 1'b0;
    endtask

    // AHB completion monitor
    initial begin
        int unsigned cnt = 0;
        bit          busy = 0;
        logic        prev_resp = 1'b0;
        logic        prev_rdy = 1'b1;
        ahb_rec_t    e;
        forever begin
            @(negedge hclk);
            #2;
            if (!hreset_n) begin
                busy = 0;
                prev_resp = 1'b0;
                prev_rdy = 1'b1;
                continue;
            end
            if (busy) begin
                cnt++;
                if (hreadyout) begin
                    busy = 0;
                    check("ahb_exp_avail", {63'd0, ahb_q.size() > 0}, 64'd1);
                    if (ahb_q.size() > 0) begin
                        e = ahb_q.pop_front();
                        check("ahb_hresp", {63'd0, hresp}, {63'd0, e.resp});
                        check("ahb_latency", 64'(cnt), 64'(e.lat));
                        check("ahb_hrdata", 64'(hrdata), 64'(e.rdata));
                        if (e.resp)
                            check("ahb_err_first_cycle", {62'd0, prev_resp, prev_rdy}, 64'd2);
                    end
                end
            end
            if (hsel && hready && htrans[1] && hreadyout) begin
                busy = 1;
                cnt  = 0;
            end
            prev_resp = hresp;
            prev_rdy  = hreadyout;
        end
    end

    // APB slave responder and checker
    initial begin
        apb_rec_t    cur;
        int unsigned remaining = 0;
        int unsigned acc_cnt = 0;
        bit          in_acc = 0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        forever begin
            @(negedge hclk);
            if (!hreset_n) begin
                in_acc  = 0;
                pready  = 1'b0;
                pslverr = 1'b0;
                continue;
            end
            if (in_acc && !(psel_vec != 0 && penable)) begin
                check("apb_access_cycles", 64'(acc_cnt), 64'(cur.cycles));
                in_acc = 0;
            end
            if (psel_vec != 0 && !penable) begin
                check("apb_exp_avail", {63'd0, apb_q.size() > 0}, 64'd1);
                if (apb_q.size() > 0) cur = apb_q.pop_front();
                check("apb_setup_sel", 64'(psel_vec), 64'(cur.sel));
                check("apb_setup_addr", 64'(paddr), 64'(cur.paddr));
                check("apb_setup_write", {63'd0, pwrite}, {63'd0, cur.wr});
                if (cur.wr) check("apb_setup_wdata", 64'(pwdata), 64'(cur.wdata));
                remaining = cur.waits;
                acc_cnt   = 0;
                pready    = $urandom;
                pslverr   = $urandom;
                prdata    = $urandom;
            end else if (psel_vec != 0 && penable) begin
                in_acc = 1;
                acc_cnt++;
                check("apb_access_sel", 64'(psel_vec), 64'(cur.sel));
                check("apb_access_addr", 64'(paddr), 64'(cur.paddr));
                check("apb_access_write", {63'd0, pwrite}, {63'd0, cur.wr});
                if (cur.wr) check("apb_access_wdata", 64'(pwdata), 64'(cur.wdata));
                if (remaining == 0) begin
                    pready  = 1'b1;
                    pslverr = cur.err;
                    prdata  = cur.rdata;
                end else begin
                    remaining--;
                    pready  = 1'b0;
                    pslverr = $urandom;
                    prdata  = $urandom;
                end
            end else begin
                pready  = $urandom;
                pslverr = $urandom;
                prdata  = $urandom;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(string tag);
        check({tag, "_hreadyout"}, {63'd0, hreadyout}, 64'd1);
        check({tag, "_hresp"}, {63'd0, hresp}, 64'd0);
        check({tag, "_hrdata"}, 64'(hrdata), 64'd0);
        check({tag, "_psel"}, 64'(psel_vec), 64'd0);
        check({tag, "_penable"}, {63'd0, penable}, 64'd0);
        check({tag, "_paddr"}, 64'(paddr), 64'd0);
        check({tag, "_pwrite"}, {63'd0, pwrite}, 64'd0);
        check({tag, "_pwdata"}, 64'(pwdata), 64'd0);
    endtask

    initial begin
        logic [31:0] r, a, d, rd;
        int unsigned idx, size, waits, n;
        hreset_n = 1'b0;
        hsel     = 1'b0;
        hready   = 1'b1;
        htrans   = HTRANS_IDLE;
        haddr    = '0;
        hwrite   = 1'b0;
        hsize    = '0;
        hburst   = '0;
        hwdata   = '0;
        repeat (2) @(negedge hclk);
        #3;
        check_reset_values("reset");
        @(negedge hclk);
        #3;
        hreset_n = 1'b1;

        issue(32'h0000_3004, 1, 2, 32'h1234_5678, 0, 0, 32'h0);
        issue(32'h0000_5000, 0, 2, 32'h0, 3, 0, 32'hDEAD_BEEF);
        issue(32'h0000_C000, 0, 2, 32'h0, 0, 0, 32'h0);
        issue(32'h0000_2010, 1, 2, 32'hCAFE_0001, 0, 1, 32'h0);
        issue(32'h0000_2014, 0, 1, 32'h0, 1, 0, 32'h1357_9BDF);
        issue(32'h0000_1000, 1, 0, 32'h0000_00AA, 1000, 0, 32'h0);
        issue(32'h0000_B008, 0, 2, 32'h0, 7, 0, 32'h8642_0ACE);
        issue(32'h0000_0000, 1, 3, 32'hFFFF_FFFF, 0, 0, 32'h0);
        idle_xfer();

        // Reset in the middle of an ACCESS phase
        issue(32'h0000_7010, 1, 2, 32'hA5A5_1234, 5, 0, 32'h0);
        n = 0;
        while (!penable && n < 50) begin
            @(negedge hclk);
            n++;
        end
        check("reset_reach_access", {63'd0, penable}, 64'd1);
        @(negedge hclk);
        #3;
        hreset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        ahb_q.delete();
        apb_q.delete();
        model_rdata = '0;
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        repeat (2) @(negedge hclk);
        #3;
        hreset_n = 1'b1;
        issue(32'h0000_7010, 0, 2, 32'h0, 2, 0, 32'h0BAD_F00D);

        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            if (r[3:0] == 0) begin
                idle_xfer();
                continue;
            end
            idx   = $urandom_range(0, 13);
            a     = $urandom;
            a     = {a[31:16], 4'(idx), a[11:2], 2'b00};
            size  = (r[7:5] == 0) ? 3 : $urandom_range(0, 2);
            n     = $urandom_range(0, 39);
            waits = (n == 0) ? 1000 : (n == 1) ? TMO - 1 : $urandom_range(0, 3);
            d     = $urandom;
            rd    = $urandom;
            issue(a, r[8], size, d, waits, r[11:9] == 0, rd);
        end

        n = 0;
        while ((ahb_q.size() != 0 || apb_q.size() != 0) && n < 300) begin
            @(negedge hclk);
            n++;
        end
        repeat (3) @(negedge hclk);
        check("drain_ahb", 64'(ahb_q.size()), 64'd0);
        check("drain_apb", 64'(apb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
